// File: rtl/video_timing_pkg.sv
// Shared 720p timing constants, total derivation and FSM state type for the
// video timing generator.
package video_timing_pkg;

  localparam int VTG_H_ACTIVE = 1280;
  localparam int VTG_H_FP     = 110;
  localparam int VTG_H_SYNC   = 40;
  localparam int VTG_H_BP     = 220;
  localparam int VTG_V_ACTIVE = 720;
  localparam int VTG_V_FP     = 5;
  localparam int VTG_V_SYNC   = 5;
  localparam int VTG_V_BP     = 20;

  function automatic int vtg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int VTG_H_TOTAL = vtg_total(VTG_H_ACTIVE, VTG_H_FP, VTG_H_SYNC, VTG_H_BP);
  localparam int VTG_V_TOTAL = vtg_total(VTG_V_ACTIVE, VTG_V_FP, VTG_V_SYNC, VTG_V_BP);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vtg_state_t;

endpackage

// File: rtl/vtg_axis_counter.sv
// One timing axis: position counter with wrap, registered sync window and a
// look-ahead "next position is visible" flag for the parent's registered o_de.
module vtg_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE   = VTG_H_ACTIVE,
  parameter int FP       = VTG_H_FP,
  parameter int SYNC     = VTG_H_SYNC,
  parameter int BP       = VTG_H_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count,
  output logic        at_end,
  output logic        active_nxt,
  output logic        sync
);

  localparam logic [15:0] LAST       = 16'(vtg_total(ACTIVE, FP, SYNC, BP) - 1);
  localparam logic [15:0] ACT_END    = 16'(ACTIVE);
  localparam logic [15:0] SYNC_START = 16'(ACTIVE + FP);
  localparam logic [15:0] SYNC_END   = 16'(ACTIVE + FP + SYNC);

  logic [15:0] count_nxt;
  logic        sync_nxt;

  assign at_end = (count == LAST);

  // Next position: clear wins, otherwise step with wrap at the last position.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = 16'd0;
    end else if (inc) begin
      if (at_end) begin
        count_nxt = 16'd0;
      end else begin
        count_nxt = count + 16'd1;
      end
    end else begin
      count_nxt = count;
    end
  end

  assign active_nxt = (count_nxt < ACT_END);
  assign sync_nxt   = ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ? SYNC_POL : ~SYNC_POL;

  // Sync is decoded from the next position so it lands in the same cycle as count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
      sync  <= ~SYNC_POL;
    end else begin
      count <= count_nxt;
      sync  <= sync_nxt;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator (default 1280x720) with IDLE/RUN/STOPPING control.
// Define VTG_FRAME_COUNT_EN to add the o_frame_cnt frame counter output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VTG_H_ACTIVE,
  parameter int H_FP     = VTG_H_FP,
  parameter int H_SYNC   = VTG_H_SYNC,
  parameter int H_BP     = VTG_H_BP,
  parameter int V_ACTIVE = VTG_V_ACTIVE,
  parameter int V_FP     = VTG_V_FP,
  parameter int V_SYNC   = VTG_V_SYNC,
  parameter int V_BP     = VTG_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic        o_h_sync,
  output logic        o_v_sync,
  output logic        o_de,
  output logic        o_frame_start,
  output logic        o_running
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  vtg_state_t state, state_nxt;
  logic h_at_end, v_at_end, h_act_nxt, v_act_nxt;
  logic frame_end, run_nxt, step, frame_start_nxt;

  assign frame_end = h_at_end & v_at_end;

  // Next-state: a stop request lets the current frame finish before idling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_en) state_nxt = RUN;
        else      state_nxt = IDLE;
      end
      RUN: begin
        if (!i_en) state_nxt = STOPPING;
        else       state_nxt = RUN;
      end
      STOPPING: begin
        if (i_en)           state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
        else                state_nxt = STOPPING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign run_nxt         = (state_nxt != IDLE);
  // Counters step only while already running; the IDLE->RUN edge presents (0,0).
  assign step            = (state != IDLE) && run_nxt;
  assign frame_start_nxt = run_nxt && ((state == IDLE) || frame_end);

  vtg_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h_axis (
    .clk(i_clk), .rst(i_rst), .clr(~step), .inc(step),
    .count(o_x), .at_end(h_at_end), .active_nxt(h_act_nxt), .sync(o_h_sync)
  );

  vtg_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v_axis (
    .clk(i_clk), .rst(i_rst), .clr(~step), .inc(step & h_at_end),
    .count(o_y), .at_end(v_at_end), .active_nxt(v_act_nxt), .sync(o_v_sync)
  );

  // State and per-pixel flags, all aligned with the counter outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      o_de          <= 1'b0;
      o_frame_start <= 1'b0;
      o_running     <= 1'b0;
    end else begin
      state         <= state_nxt;
      o_de          <= run_nxt & h_act_nxt & v_act_nxt;
      o_frame_start <= frame_start_nxt;
      o_running     <= run_nxt;
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  // Counts frame_start pulses already presented; wraps naturally at 16 bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= 16'd0;
    end else if (o_frame_start) begin
      o_frame_cnt <= o_frame_cnt + 16'd1;
    end else begin
      o_frame_cnt <= o_frame_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen on a reduced raster, checked against a
// frame-position model (linear pixel index within the frame).
module tb_video_timing_gen;

  localparam int HA = 16, HF = 4, HS = 3, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 28
  localparam int VT = VA + VF + VS + VB;   // 13
  localparam int FRAME = HT * VT;          // 364
  localparam bit POL = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] x, y;
  logic        hs, vs, de, fs, running;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // model: on/off, linear position, "en was low at the last running edge"
  bit m_on, m_stop, m_fs;
  int m_pos;
  int m_fcnt;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .o_x(x), .o_y(y), .o_h_sync(hs), .o_v_sync(vs),
    .o_de(de), .o_frame_start(fs), .o_running(running)
`ifdef VTG_FRAME_COUNT_EN
    , .o_frame_cnt(frame_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_on = 1'b0; m_stop = 1'b0; m_fs = 1'b0; m_pos = 0; m_fcnt = 0;
  endfunction

  function automatic void model_edge(input bit en_v);
    if (m_fs) m_fcnt = (m_fcnt + 1) % 65536;
    if (!m_on) begin
      if (en_v) begin
        m_on = 1'b1; m_pos = 0; m_fs = 1'b1; m_stop = 1'b0;
      end else begin
        m_fs = 1'b0;
      end
    end else if (m_stop && !en_v && m_pos == FRAME - 1) begin
      m_on = 1'b0; m_pos = 0; m_fs = 1'b0; m_stop = 1'b0;
    end else begin
      m_pos  = (m_pos + 1) % FRAME;
      m_fs   = (m_pos == 0);
      m_stop = !en_v;
    end
  endfunction

  task automatic check_outputs();
    int ex, ey;
    bit ehs, evs;
    ex  = m_pos % HT;
    ey  = m_pos / HT;
    ehs = (m_on && ex >= HA + HF && ex < HA + HF + HS) ? POL : !POL;
    evs = (m_on && ey >= VA + VF && ey < VA + VF + VS) ? POL : !POL;
    check_val("x", 32'(x), 32'(ex));
    check_val("y", 32'(y), 32'(ey));
    check_val("h_sync", 32'(hs), 32'(ehs));
    check_val("v_sync", 32'(vs), 32'(evs));
    check_val("de", 32'(de), 32'(m_on && ex < HA && ey < VA));
    check_val("frame_start", 32'(fs), 32'(m_fs));
    check_val("running", 32'(running), 32'(m_on));
`ifdef VTG_FRAME_COUNT_EN
    check_val("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
`endif
  endtask

  task automatic step_cycle(input bit en_v);
    en = en_v;
    @(posedge clk);
    model_edge(en_v);
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // Run with a fixed enable until the model reaches a frame position (bounded).
  task automatic run_to(input bit en_v, input int px, input int py);
    int budget;
    budget = 2 * FRAME + 4;
    while (!(m_on && m_pos == py * HT + px) && budget > 0) begin
      step_cycle(en_v);
      budget--;
    end
    check_val("reach_pos_timeout", 32'(budget == 0), 32'd0);
  endtask

  initial begin
    bit en_r;
    rst = 1'b1;
    en  = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step_cycle(1'b0);

    // start, run past first visible edge, a full frame and a wrap
    for (int i = 0; i < 2 * FRAME + 10; i++) step_cycle(1'b1);

    // drop enable mid-frame: the frame drains to the last pixel then idles
    run_to(1'b1, 10, 3);
    for (int i = 0; i < FRAME; i++) step_cycle(1'b0);
    check_val("idle_after_drain", 32'(running), 32'd0);

    // drop then re-raise before the end: counting has no gap
    step_cycle(1'b1);
    run_to(1'b1, 20, 0);
    run_to(1'b0, 5, VT - 2);
    for (int i = 0; i < 2 * HT + 30; i++) step_cycle(1'b1);
    run_to(1'b1, 0, 0);
    check_val("restart_frame_start", 32'(fs), 32'd1);

    // reset mid-frame, then restart from (0,0)
    run_to(1'b1, 8, 3);
    pulse_reset();
    for (int i = 0; i < 5; i++) step_cycle(1'b1);

    // randomized enable activity with occasional resets
    en_r = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(149, 0) == 0) en_r = !en_r;
      if ($urandom_range(1999, 0) == 0) pulse_reset();
      else step_cycle(en_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
